// File: rtl/johnson_decoder_monitor.sv
// johnson_decoder_monitor: decodes a Johnson code stream to binary, checks legality and succession, tracks lock and counts errors; `JOHNSON_DEC_ONEHOT_EN adds a one-hot index output
module johnson_decoder_monitor #(
    parameter int N        = 10,
    parameter int IDX_W    = 5,
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     code,
    input  logic             code_valid,
    input  logic             clear_err,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
`ifdef JOHNSON_DEC_ONEHOT_EN
    ,
    output logic [2*N-1:0]   onehot
`else
`endif
);

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

    localparam logic [3:0]       LOCK_CNT = 4'(LOCK_LEN);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(2 * N - 1);

    state_t           state, state_nxt;
    logic [3:0]       good_cnt, good_nxt;
    logic [IDX_W-1:0] ones, trans, dec, succ;
    logic             legal, is_succ, seq_nxt, err_inc;

    // count ones and bit transitions; decode and predict the next index
    always_comb begin
        ones  = '0;
        trans = '0;
        for (int i = 0; i < N; i++) ones = ones + IDX_W'(code[i]);
        for (int i = 0; i < N - 1; i++) trans = trans + IDX_W'(code[i] ^ code[i+1]);
        legal   = trans <= IDX_W'(1);
        dec     = !code[N-1] ? ones : code[0] ? IDX_W'(N) : IDX_W'(2 * N) - ones;
        succ    = (index == LAST) ? '0 : index + IDX_W'(1);
        is_succ = dec == succ;
    end

    // lock tracking: a legal seed plus LOCK_LEN correct successors locks
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        seq_nxt   = 1'b0;
        err_inc   = 1'b0;
        if (code_valid) begin
            if (!legal) begin
                state_nxt = HUNT;
                good_nxt  = '0;
                err_inc   = state == LOCKED;
            end else if (state == HUNT) begin
                state_nxt = CONFIRM;
                good_nxt  = 4'd1;
            end else if (!is_succ) begin
                state_nxt = CONFIRM;
                good_nxt  = 4'd1;
                seq_nxt   = 1'b1;
                err_inc   = state == LOCKED;
            end else if (state == CONFIRM) begin
                good_nxt  = good_cnt + 4'd1;
                state_nxt = (good_cnt >= LOCK_CNT) ? LOCKED : CONFIRM;
            end
        end
    end

    // state, index and status pulses; index holds across illegal words
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= HUNT;
            good_cnt    <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_nxt;
            good_cnt    <= good_nxt;
            index_valid <= code_valid && legal;
            illegal     <= code_valid && !legal;
            seq_err     <= seq_nxt;
            locked      <= state_nxt == LOCKED;
            if (code_valid && legal) index <= dec;
        end
    end

    // saturating error counter; clear beats a simultaneous increment
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) err_count <= '0;
        else if (clear_err) err_count <= '0;
        else if (err_inc && err_count != '1) err_count <= err_count + ERR_W'(1);
    end

`ifdef JOHNSON_DEC_ONEHOT_EN
    // one-hot image of the most recent legal index
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) onehot <= '0;
        else if (code_valid && legal) onehot <= (2*N)'(1) << dec;
    end
`else
`endif

endmodule
